otter_fetch_queue: RTL and testbench
====================================

Name: otter_fetch_queue

Overview:
- Instruction-fetch front end of the pipelined Otter CPU; sits directly upstream of the decode stage.
- Owns the fetch PC and drives the instruction port of the unified Memory (1-cycle synchronous read).
- Buffers returned instructions with their PCs in a small queue; hands them to decode via valid/ready.
- Accepts redirects (taken branch, JAL, JALR) from execute, flushing wrong-path instructions.

Parameters:
- DEPTH, 4, queue entries (power of two, ≥2).
- RESET_PC, 32'h0000_0000, fetch address after reset.
- ADDR_W, 14, word-address width to memory port 1 (PC[ADDR_W+1:2]).

Ports:
- CLK  in  1  clock, all state on rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- REDIRECT  in  1  execute-stage redirect strobe (single cycle).
- REDIRECT_PC  in  32  redirect target; bits [1:0] ignored (treated as 0).
- MEM_RDEN1  out  1  instruction read enable.
- MEM_ADDR1  out  ADDR_W  instruction word address.
- MEM_DOUT1  in  32  instruction data, valid one cycle after the MEM_RDEN1 cycle.
- DE_VALID  out  1  DE_IR/DE_PC hold a valid instruction.
- DE_READY  in  1  decode accepts this cycle.
- DE_IR  out  32  instruction to decode.
- DE_PC  out  32  PC of DE_IR.

Behaviour:
- Reset (RESET_N low, async):
  - fetch_pc=RESET_PC; queue empty; count=0; inflight=0.
  - MEM_RDEN1=0, DE_VALID=0, DE_IR=0, DE_PC=0.
- Issue address (combinational): addr = REDIRECT ? {REDIRECT_PC[31:2],2'b00} : fetch_pc; MEM_ADDR1 = addr[ADDR_W+1:2].
- pop = DE_VALID & DE_READY.
- Issue condition: MEM_RDEN1 = RESET_N & (REDIRECT | (count + inflight − pop < DEPTH)). Queue can never overflow.
- On issue: fetch_pc ← addr+4 (mod 2^32, wrap silently); inflight ← 1; inflight_pc ← addr. With no issue, inflight ← 0.
- Return: when inflight=1 and REDIRECT=0, {MEM_DOUT1, inflight_pc} is pushed at tail this cycle.
- Pop removes head; simultaneous push+pop with count unchanged is legal at any occupancy, including full.
- Redirect cycle:
  - Returning data is discarded; queue flushed (count←0, pointers←0).
  - DE_VALID forced 0, so no pop; new read of REDIRECT_PC issued same cycle.
  - First target instruction is visible at DE_VALID two cycles after REDIRECT.
- Back-to-back REDIRECT: the later one wins; each discards the prior in-flight read.
- DE_VALID = (count≠0) & ~REDIRECT; DE_IR/DE_PC = head entry.
- Empty queue with DE_READY high: no pop; DE_IR/DE_PC hold the last head value (don't-care for checking).
- Full queue with DE_READY low: no issue; fetch_pc holds; no instruction lost or duplicated.
- Sequencing FSM (2 states):
  - STREAM: issuing each cycle. Go to HOLD when the issue condition is false and REDIRECT=0.
  - HOLD: no issue. Return to STREAM when the issue condition becomes true or on REDIRECT.
  - State is also exported internally for the optional counter.
- Reset asserted mid-operation: everything returns to reset values immediately; the in-flight read is dropped.

Optional Feature:
- OTTER_FQ_BYPASS_EN.
- Defined: when count=0 and a valid return arrives, DE_IR/DE_PC come straight from MEM_DOUT1/inflight_pc and DE_VALID=1 the same cycle.
  - If popped, the entry is not written; if not popped, it is written normally.
  - First target instruction is visible 1 cycle after REDIRECT.
- Undefined: every return goes through the queue; 2-cycle minimum from issue to DE_VALID.

Decomposition:
- Shared package otter_fetch_pkg:
  - fq_entry_t packed struct {logic [31:0] ir; logic [31:0] pc;}.
  - fq_state_t enum {STREAM, HOLD}.
  - Constant NOP_IR = 32'h0000_0013.
- One sub-module, otter_fq_fifo:
  - Parameterized DEPTH, fq_entry_t storage.
  - push/pop/flush inputs; count/head outputs; flush has priority over push.

Test Plan:
- Reset release, DE_READY=1 held: MEM_ADDR1 sequence 0,1,2,…; DE_PC 0x0,0x4,0x8 on consecutive cycles once streaming. DE_IR matches memory image; first DE_VALID at cycle 2 (cycle 1 with bypass).
- DE_READY=0 for 10 cycles: exactly DEPTH=4 entries fetched, then MEM_RDEN1=0. On DE_READY=1, DE_PC continues 0x0,0x4,… with no gap or duplicate.
- REDIRECT with REDIRECT_PC=0x0000_0100 while queue holds 3 entries: same cycle DE_VALID=0 and MEM_ADDR1=0x40. Next DE_PC=0x100, then 0x104; no stale PC ever presented.
- REDIRECT on two consecutive cycles (0x200 then 0x300): first valid DE_PC=0x300; 0x200 never appears.
- REDIRECT_PC=0x0000_0103: DE_PC=0x100.
- fetch_pc at 0xFFFF_FFFC, streaming: next DE_PC=0x0000_0000.
- RESET_N pulsed low mid-stream (async, between edges): outputs zero immediately; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/otter_fetch_pkg.sv
// Shared types for the Otter instruction-fetch queue: queue entry layout,
// sequencing states and the canonical NOP encoding.
package otter_fetch_pkg;

  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] pc;
  } fq_entry_t;

  typedef enum logic {
    STREAM = 1'b0,
    HOLD   = 1'b1
  } fq_state_t;

  localparam logic [31:0] NOP_IR = 32'h0000_0013;

endpackage

// File: rtl/otter_fq_fifo.sv
// Small circular buffer of {ir, pc} entries for the fetch queue.
// Flush wins over push; storage is cleared on reset so the head reads as zero.
module otter_fq_fifo
  import otter_fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  fq_entry_t        push_data_i,
  output logic [CNT_W-1:0] count_o,
  output fq_entry_t        head_o
);

  fq_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/otter_fetch_queue.sv
// Otter fetch front end: owns the fetch PC, drives memory port 1 and queues
// returned instructions for decode. Optional same-cycle bypass: OTTER_FQ_BYPASS_EN.
module otter_fetch_queue
  import otter_fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 14
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              REDIRECT,
  input  logic [31:0]       REDIRECT_PC,
  output logic              MEM_RDEN1,
  output logic [ADDR_W-1:0] MEM_ADDR1,
  input  logic [31:0]       MEM_DOUT1,
  output logic              DE_VALID,
  input  logic              DE_READY,
  output logic [31:0]       DE_IR,
  output logic [31:0]       DE_PC
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      inflight_pc_q, inflight_pc_d;
  logic             inflight_q, inflight_d;
  fq_state_t        state_q, state_d;
  logic [31:0]      issue_addr;
  logic [CNT_W-1:0] count;
  logic [CNT_W:0]   occ;
  fq_entry_t        head, ret_entry;
  logic             ret_vld, pop, issue_ok, fifo_push, fifo_pop;

  assign issue_addr = REDIRECT ? (REDIRECT_PC & 32'hFFFF_FFFC) : fetch_pc_q;
  assign MEM_ADDR1  = issue_addr[ADDR_W+1:2];
  assign ret_vld    = inflight_q & ~REDIRECT;
  assign ret_entry  = '{ir: MEM_DOUT1, pc: inflight_pc_q};
  assign pop        = DE_VALID & DE_READY;

  // Occupancy once the in-flight word lands and this cycle's pop leaves.
  assign occ      = {1'b0, count} + (CNT_W + 1)'(inflight_q) - (CNT_W + 1)'(pop);
  assign issue_ok = REDIRECT | (occ < DEPTH_C);

`ifdef OTTER_FQ_BYPASS_EN
  logic byp;
  assign byp       = ret_vld & (count == '0);
  assign DE_VALID  = ((count != '0) | byp) & ~REDIRECT;
  assign DE_IR     = byp ? MEM_DOUT1 : head.ir;
  assign DE_PC     = byp ? inflight_pc_q : head.pc;
  assign fifo_push = ret_vld & ~(byp & DE_READY);
  assign fifo_pop  = pop & ~byp;
`else
  assign DE_VALID  = (count != '0) & ~REDIRECT;
  assign DE_IR     = head.ir;
  assign DE_PC     = head.pc;
  assign fifo_push = ret_vld;
  assign fifo_pop  = pop;
`endif

  otter_fq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i       (CLK),
    .rst_ni      (RESET_N),
    .push_i      (fifo_push),
    .pop_i       (fifo_pop),
    .flush_i     (REDIRECT),
    .push_data_i (ret_entry),
    .count_o     (count),
    .head_o      (head)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state_q <= STREAM;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      STREAM: if (!issue_ok && !REDIRECT) state_d = HOLD;
      HOLD:   if (issue_ok || REDIRECT)   state_d = STREAM;
      default: state_d = STREAM;
    endcase
  end

  // HOLD resumes issuing in the same cycle the condition clears.
  always_comb begin
    MEM_RDEN1 = 1'b0;
    unique case (state_q)
      STREAM:  MEM_RDEN1 = RESET_N & issue_ok;
      HOLD:    MEM_RDEN1 = RESET_N & issue_ok;
      default: MEM_RDEN1 = 1'b0;
    endcase
  end

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_pc_d = inflight_pc_q;
    inflight_d    = 1'b0;
    if (MEM_RDEN1) begin
      fetch_pc_d    = issue_addr + 32'd4;
      inflight_pc_d = issue_addr;
      inflight_d    = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      fetch_pc_q    <= RESET_PC;
      inflight_pc_q <= '0;
      inflight_q    <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_pc_q <= inflight_pc_d;
      inflight_q    <= inflight_d;
    end
  end

endmodule

// File: tb/tb_otter_fetch_queue.sv
// Bench for otter_fetch_queue: directed scenarios plus randomized ready/redirect
// traffic against an in-order PC-stream reference model.
module tb_otter_fetch_queue;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
`ifdef OTTER_FQ_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic        CLK = 1'b0;
  logic        RESET_N, REDIRECT, DE_READY;
  logic [31:0] REDIRECT_PC;
  logic        MEM_RDEN1, DE_VALID;
  logic [13:0] MEM_ADDR1;
  logic [31:0] MEM_DOUT1, DE_IR, DE_PC;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_pc;

  otter_fetch_queue #(.DEPTH(4), .RESET_PC(RST_PC), .ADDR_W(14)) dut (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .REDIRECT    (REDIRECT),
    .REDIRECT_PC (REDIRECT_PC),
    .MEM_RDEN1   (MEM_RDEN1),
    .MEM_ADDR1   (MEM_ADDR1),
    .MEM_DOUT1   (MEM_DOUT1),
    .DE_VALID    (DE_VALID),
    .DE_READY    (DE_READY),
    .DE_IR       (DE_IR),
    .DE_PC       (DE_PC)
  );

  always #5 CLK = ~CLK;

  // Memory image: each word address maps to a distinct instruction word.
  function automatic logic [31:0] img(input logic [13:0] a);
    return {a, 2'b01, ~a, 2'b10};
  endfunction

  always @(posedge CLK) begin
    if (MEM_RDEN1) MEM_DOUT1 <= img(MEM_ADDR1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: decode must see one contiguous PC stream from the last
  // redirect target (or reset PC), each with its memory-image instruction.
  always @(negedge CLK) begin
    if (!RESET_N) begin
      exp_pc = RST_PC;
    end else if (REDIRECT) begin
      chk("redir_vld", 64'(DE_VALID), 64'(1'b0));
      chk("redir_rden", 64'(MEM_RDEN1), 64'(1'b1));
      chk("redir_addr", 64'(MEM_ADDR1), 64'(REDIRECT_PC[15:2]));
      exp_pc = REDIRECT_PC & 32'hFFFF_FFFC;
    end else if (DE_VALID) begin
      chk("stream_pc", 64'(DE_PC), 64'(exp_pc));
      chk("stream_ir", 64'(DE_IR), 64'(img(exp_pc[15:2])));
      if (DE_READY) exp_pc = exp_pc + 32'd4;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Counts cycles until DE_VALID; the first negedge seen is one cycle after the caller's cycle.
  task automatic wait_valid(input string tag, output int n);
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge CLK);
      if (DE_VALID) begin
        n = i;
        break;
      end
    end
    if (n == 0) chk({tag, "_timeout"}, 64'(0), 64'(1));
  endtask

  task automatic do_reset(input logic rdy);
    tick();
    RESET_N  = 1'b0;
    REDIRECT = 1'b0;
    DE_READY = rdy;
    tick();
    RESET_N  = 1'b1;
  endtask

  initial begin
    int n, first, nrd, pready;
    RESET_N     = 1'b0;
    REDIRECT    = 1'b0;
    REDIRECT_PC = '0;
    DE_READY    = 1'b1;

    // Reset state and streaming from reset
    tick();
    chk("rst_rden", 64'(MEM_RDEN1), 64'(1'b0));
    chk("rst_vld", 64'(DE_VALID), 64'(1'b0));
    chk("rst_ir", 64'(DE_IR), 64'(0));
    chk("rst_pc", 64'(DE_PC), 64'(0));
    tick();
    RESET_N = 1'b1;
    first = -1;
    for (int k = 0; k < 6; k++) begin
      @(negedge CLK);
      chk("seq_addr", 64'(MEM_ADDR1), 64'(k));
      chk("seq_rden", 64'(MEM_RDEN1), 64'(1'b1));
      if (DE_VALID && first < 0) first = k;
      if (k >= LAT && k <= LAT + 2) chk("seq_depc", 64'(DE_PC), 64'((k - LAT) * 4));
    end
    chk("first_valid_cycle", 64'(first), 64'(LAT));

    // Stall: exactly DEPTH reads, then no issue until decode drains
    do_reset(1'b0);
    nrd = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK);
      if (MEM_RDEN1) nrd++;
    end
    chk("stall_reads", 64'(nrd), 64'(4));
    chk("stall_rden_off", 64'(MEM_RDEN1), 64'(1'b0));
    tick();
    DE_READY = 1'b1;
    @(negedge CLK);
    chk("stall_resume_vld", 64'(DE_VALID), 64'(1'b1));
    chk("stall_resume_pc", 64'(DE_PC), 64'(0));
    repeat (8) @(negedge CLK);

    // Redirect while three entries are queued
    do_reset(1'b0);
    repeat (4) tick();
    REDIRECT    = 1'b1;
    REDIRECT_PC = 32'h0000_0100;
    DE_READY    = 1'b1;
    @(negedge CLK);
    chk("r3_vld", 64'(DE_VALID), 64'(1'b0));
    chk("r3_addr", 64'(MEM_ADDR1), 64'(14'h40));
    tick();
    REDIRECT = 1'b0;
    wait_valid("r3", n);
    chk("r3_latency", 64'(n), 64'(LAT));
    chk("r3_pc0", 64'(DE_PC), 64'(32'h100));
    @(negedge CLK);
    chk("r3_pc1", 64'(DE_PC), 64'(32'h104));

    // Back-to-back redirects: the later target wins
    tick();
    REDIRECT    = 1'b1;
    REDIRECT_PC = 32'h0000_0200;
    tick();
    REDIRECT_PC = 32'h0000_0300;
    tick();
    REDIRECT = 1'b0;
    wait_valid("b2b", n);
    chk("b2b_latency", 64'(n), 64'(LAT));
    chk("b2b_pc", 64'(DE_PC), 64'(32'h300));

    // Low target bits ignored
    tick();
    REDIRECT    = 1'b1;
    REDIRECT_PC = 32'h0000_0103;
    tick();
    REDIRECT = 1'b0;
    wait_valid("unal", n);
    chk("unal_pc", 64'(DE_PC), 64'(32'h100));

    // PC wraps past the top of the address space
    tick();
    REDIRECT    = 1'b1;
    REDIRECT_PC = 32'hFFFF_FFF8;
    tick();
    REDIRECT = 1'b0;
    wait_valid("wrap", n);
    chk("wrap_pc0", 64'(DE_PC), 64'(32'hFFFF_FFF8));
    @(negedge CLK);
    chk("wrap_pc1", 64'(DE_PC), 64'(32'hFFFF_FFFC));
    @(negedge CLK);
    chk("wrap_pc2", 64'(DE_PC), 64'(32'h0000_0000));
    chk("wrap_ir2", 64'(DE_IR), 64'(img(14'h0)));

    // Asynchronous reset between edges while streaming
    repeat (3) tick();
    @(posedge CLK);
    #2;
    RESET_N = 1'b0;
    #1;
    chk("areset_vld", 64'(DE_VALID), 64'(1'b0));
    chk("areset_rden", 64'(MEM_RDEN1), 64'(1'b0));
    chk("areset_ir", 64'(DE_IR), 64'(0));
    chk("areset_pc", 64'(DE_PC), 64'(0));
    tick();
    RESET_N = 1'b1;
    @(negedge CLK);
    chk("areset_restart_addr", 64'(MEM_ADDR1), 64'(RST_PC[15:2]));
    wait_valid("areset", n);
    chk("areset_latency", 64'(n), 64'(LAT));
    chk("areset_first_pc", 64'(DE_PC), 64'(RST_PC));

    // Randomized ready and redirect traffic, checked by the reference model
    pready = 7;
    for (int c = 0; c < 800; c++) begin
      tick();
      if (c % 50 == 0) pready = $urandom_range(1, 10);
      DE_READY = ($urandom_range(1, 10) <= pready);
      REDIRECT = ($urandom_range(0, 15) == 0);
      REDIRECT_PC = $urandom();
    end
    tick();
    REDIRECT = 1'b0;
    DE_READY = 1'b1;
    repeat (10) @(negedge CLK);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
